full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Binary adder: A + B + Cin produces Sum and Cout.
- WIDTH=1 default is the classic 1-bit full adder used as the arithmetic leaf cell in datapath blocks.
- Wider instances are a ripple-carry chain of 1-bit cells.
- Optional output register for pipelined datapaths; default build is purely combinational from inputs to outputs.

Parameters:
- WIDTH, 1, operand width in bits (>=1).
- REG_OUT, 0, 0 = outputs combinational; 1 = Sum/Cout/Ovf registered on clk, 1-cycle latency.

Ports:
- clk  input  1  system clock; used only when REG_OUT=1.
- rst  input  1  synchronous, active-high reset; used only when REG_OUT=1.
- A  input  WIDTH  addend.
- B  input  WIDTH  addend.
- Cin  input  1  carry in.
- Sum  output  WIDTH  low WIDTH bits of A+B+Cin.
- Cout  output  1  carry out of MSB (bit WIDTH of A+B+Cin).
- Ovf  output  1  two's-complement signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Bit cell equations: s = a^b^c; co = (a&b)|(a&c)|(b&c).
- Ripple chain: c[0] = Cin; c[i+1] = co of cell i; Cout = c[WIDTH]; Ovf = c[WIDTH]^c[WIDTH-1].
  - For WIDTH=1: Ovf = Cout^Cin.
- Arithmetic: {Cout,Sum} equals the unsigned (WIDTH+1)-bit sum A+B+Cin exactly for every input combination.
  - No saturation; wrap-around is visible only through Cout/Ovf.
- REG_OUT=0:
  - No state.
  - Outputs settle within the same delta/timestep as any input change.
  - clk and rst are ignored.
  - Outputs are valid regardless of reset.
  - X on any input propagates as X on dependent outputs.
- REG_OUT=1:
  - On posedge clk with rst=1: Sum=0, Cout=0, Ovf=0.
  - On posedge clk with rst=0: register the combinational results.
  - Latency exactly 1 cycle; a new result every cycle (throughput 1/cycle).
  - Reset mid-stream discards the in-flight result; the first valid output appears the cycle after rst deasserts.
  - Reset value of every output: 0.
- No handshake and no enables; inputs are sampled continuously.

Decomposition:
- Sub-module full_adder_cell (1-bit: a, b, ci -> s, co), instantiated WIDTH times via generate.
- Output register stage lives in full_adder, inside a generate on REG_OUT.
- No shared package needed.
- Optional package adder_pkg holding a function ref_add(A,B,Cin) returning {Cout,Sum} for bench use.

Test Plan:
- WIDTH=1, REG_OUT=0, exhaustive (A,B,Cin) in the order 000,100,110,111,001,101, 50-100ns apart -> (Sum,Cout) = (0,0),(1,0),(0,1),(1,1),(1,0),(0,1).
- WIDTH=1, REG_OUT=0, all 8 combinations -> Sum = A^B^Cin, Cout = majority(A,B,Cin), Ovf = Cout^Cin; toggle clk/rst during the run -> no effect on outputs.
- WIDTH=8, REG_OUT=0: 0xFF+0x00+Cin=1 -> Sum=0x00, Cout=1 (full carry ripple).
  - 0x7F+0x01+0 -> Sum=0x80, Cout=0, Ovf=1.
  - 0x80+0x80+0 -> Sum=0x00, Cout=1, Ovf=1.
- WIDTH=8, REG_OUT=1: rst=1 for 2 cycles -> all outputs 0.
  - Then drive 0x12+0x34+1 -> Sum=0x47, Cout=0 exactly one cycle later.
  - Back-to-back vectors -> one result per cycle.
- WIDTH=8, REG_OUT=1: assert rst for 1 cycle while a result is in flight -> outputs 0 on the following edge; next vector 0xF0+0x20+0 -> Sum=0x10, Cout=1 one cycle after rst drops.
- WIDTH=4, REG_OUT=0: random 10k vectors -> {Cout,Sum} == A+B+Cin against ref_add.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared definitions for the full_adder datapath block: the bit-cell
// equations and a plain arithmetic reference sum.
package full_adder_pkg;

  localparam int REF_MAX_W = 32;

  // Sum bit of a single full-adder cell.
  function automatic logic cell_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry out of a single full-adder cell (majority of the three inputs).
  function automatic logic cell_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Reference {Cout,Sum} for operands up to REF_MAX_W bits wide.
  function automatic logic [REF_MAX_W:0] ref_add(input logic [REF_MAX_W-1:0] a,
                                                 input logic [REF_MAX_W-1:0] b,
                                                 input logic                 cin);
    return {1'b0, a} + {1'b0, b} + (REF_MAX_W+1)'(cin);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: the leaf cell of the ripple-carry chain.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Pure combinational cell; X on any input propagates to the outputs.
  always_comb begin
    s  = cell_sum(a, b, ci);
    co = cell_carry(a, b, ci);
  end

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH full-adder cells with an optional one-cycle
// output register. Ovf is the two's-complement overflow, taken as the
// carry into the MSB XOR the carry out of the MSB.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign carry[0] = Cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a  (A[i]),
        .b  (B[i]),
        .ci (carry[i]),
        .s  (sum_c[i]),
        .co (carry[i+1])
      );
    end
  endgenerate

  // Chain-level results; for WIDTH=1 carry[WIDTH-1] is Cin itself.
  always_comb begin
    cout_c = carry[WIDTH];
    ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] sum_d,  sum_q;
      logic             cout_d, cout_q;
      logic             ovf_d,  ovf_q;

      // Next register contents: the chain result, or all zeros under reset
      // so an in-flight result is discarded.
      always_comb begin
        sum_d  = sum_c;
        cout_d = cout_c;
        ovf_d  = ovf_c;
        if (rst) begin
          sum_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end
      end

      // One-cycle output stage, new result every clock.
      always_ff @(posedge clk) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end

      assign Sum  = sum_q;
      assign Cout = cout_q;
      assign Ovf  = ovf_q;
    end else begin : g_comb
      // Purely combinational build: clk and rst have no effect.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign Sum  = sum_c;
      assign Cout = cout_c;
      assign Ovf  = ovf_c;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: four instances (1-bit comb, 8-bit comb, 8-bit
// registered, 4-bit comb) driven by tasks, with expected responses queued
// at stimulus time and popped by per-instance monitors.
module tb_full_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a1, b1, c1, s1, co1, ov1;
  logic [7:0] a8c, b8c, s8c;
  logic       c8c, co8c, ov8c;
  logic [7:0] a8r, b8r, s8r;
  logic       c8r, co8r, ov8r;
  logic [3:0] a4, b4, s4;
  logic       c4, co4, ov4;

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .Sum(s1), .Cout(co1), .Ovf(ov1));
  full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (
    .clk(clk), .rst(rst), .A(a8c), .B(b8c), .Cin(c8c), .Sum(s8c), .Cout(co8c), .Ovf(ov8c));
  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
    .clk(clk), .rst(rst), .A(a8r), .B(b8r), .Cin(c8r), .Sum(s8r), .Cout(co8r), .Ovf(ov8r));
  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .Sum(s4), .Cout(co4), .Ovf(ov4));

  // ---------------- scoreboard ----------------
  // Packed response: [9]=Ovf, [8]=Cout, [7:0]=Sum (zero extended).
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q8c[$];
  logic [9:0] exp_q8r[$];
  logic [9:0] exp_q4[$];
  int checks = 0;
  int errors = 0;
  event ev1, ev8c, ev4;

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h",
               name, got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Reference model: unsigned sum for Sum/Cout, signed range test for Ovf.
  function automatic logic [9:0] model(input int w, input int a, input int b, input int cin);
    int full, half, u, sa, sb, ss;
    logic [9:0] r;
    full = 1 << w;
    half = full / 2;
    u    = a + b + cin;
    r    = '0;
    r[7:0] = 8'(u % full);
    r[8]   = (u >= full);
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    ss = sa + sb + cin;
    r[9] = (ss < -half) || (ss > half - 1);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_w1(input int a, input int b, input int cin, input int gap);
    a1 = 1'(a); b1 = 1'(b); c1 = 1'(cin);
    exp_q1.push_back(model(1, a, b, cin));
    -> ev1;
    #(gap);
  endtask

  task automatic drive_w8c(input int a, input int b, input int cin);
    a8c = 8'(a); b8c = 8'(b); c8c = 1'(cin);
    exp_q8c.push_back(model(8, a, b, cin));
    -> ev8c;
    #10;
  endtask

  task automatic drive_w4(input int a, input int b, input int cin);
    a4 = 4'(a); b4 = 4'(b); c4 = 1'(cin);
    exp_q4.push_back(model(4, a, b, cin));
    -> ev4;
    #2;
  endtask

  // Drives one cycle of the registered instance; the result is due at the
  // next rising edge.
  task automatic drive_w8r(input logic r, input int a, input int b, input int cin);
    @(negedge clk);
    rst = r; a8r = 8'(a); b8r = 8'(b); c8r = 1'(cin);
    exp_q8r.push_back(r ? 10'd0 : model(8, a, b, cin));
  endtask

  // ---------------- monitors ----------------
  initial forever begin
    @(ev1); #1;
    if (exp_q1.size() > 0) check("w1_comb", {ov1, co1, 7'b0, s1}, exp_q1.pop_front());
  end

  initial forever begin
    @(ev8c); #1;
    if (exp_q8c.size() > 0) check("w8_comb", {ov8c, co8c, s8c}, exp_q8c.pop_front());
  end

  initial forever begin
    @(ev4); #1;
    if (exp_q4.size() > 0) check("w4_rand", {ov4, co4, 4'b0, s4}, exp_q4.pop_front());
  end

  initial forever begin
    @(posedge clk); #1;
    if (exp_q8r.size() > 0) check("w8_reg", {ov8r, co8r, s8r}, exp_q8r.pop_front());
  end

  // ---------------- stimulus ----------------
  initial begin
    a1 = 0; b1 = 0; c1 = 0;
    a8c = 0; b8c = 0; c8c = 0;
    a8r = 0; b8r = 0; c8r = 0;
    a4 = 0; b4 = 0; c4 = 0;

    // 1-bit ordered sweep: (A,B,Cin) = 000,100,110,111,001,101.
    drive_w1(0, 0, 0, 60);
    drive_w1(1, 0, 0, 60);
    drive_w1(1, 1, 0, 60);
    drive_w1(1, 1, 1, 60);
    drive_w1(0, 0, 1, 60);
    drive_w1(1, 0, 1, 60);

    // 1-bit all combinations with rst toggling underneath.
    for (int k = 0; k < 8; k++) begin
      rst = ~rst;
      drive_w1((k >> 2) & 1, (k >> 1) & 1, k & 1, 13);
    end

    // 8-bit combinational boundaries, then random.
    drive_w8c(8'hFF, 8'h00, 1);
    drive_w8c(8'h7F, 8'h01, 0);
    drive_w8c(8'h80, 8'h80, 0);
    drive_w8c(8'hFF, 8'hFF, 1);
    drive_w8c(8'h80, 8'h7F, 1);
    for (int k = 0; k < 40; k++)
      drive_w8c($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));

    // 8-bit registered: two reset cycles, then a known vector.
    drive_w8r(1'b1, 8'hAA, 8'h55, 1);
    drive_w8r(1'b1, 8'hFF, 8'hFF, 1);
    drive_w8r(1'b0, 8'h12, 8'h34, 1);
    // Back-to-back vectors, one result per cycle.
    for (int k = 0; k < 30; k++)
      drive_w8r(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
    // Reset while a result is in flight, then the recovery vector.
    drive_w8r(1'b0, 8'h7F, 8'h7F, 1);
    drive_w8r(1'b1, 8'h33, 8'h44, 0);
    drive_w8r(1'b0, 8'hF0, 8'h20, 0);
    drive_w8r(1'b0, 8'h80, 8'hFF, 0);
    // Random resets mixed into the stream.
    for (int k = 0; k < 30; k++)
      drive_w8r(($urandom_range(0, 7) == 0), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;

    // 4-bit random sweep.
    for (int k = 0; k < 10000; k++)
      drive_w4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));

    // Every queued expectation must have been consumed.
    #20;
    check("drain_q1",  10'(exp_q1.size()),  10'd0);
    check("drain_q8c", 10'(exp_q8c.size()), 10'd0);
    check("drain_q8r", 10'(exp_q8r.size()), 10'd0);
    check("drain_q4",  10'(exp_q4.size()),  10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
